// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: holds the fetch address across stalls,
// presents it over a valid/ready handshake, and applies or queues trap/redirect targets.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             imem_ready,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             redirect_pending,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);
  localparam logic [XLEN-1:0] LOW_MASK = INC_V - XLEN'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pend_target, pend_target_d;
  logic            pend_trap, pend_trap_d;
  logic            misaligned_d;
  logic            accept;
  logic            locked;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] t);
    return t & ~LOW_MASK;
  endfunction

  function automatic logic has_low_bits(input logic [XLEN-1:0] t);
    return |(t & LOW_MASK);
  endfunction

  assign pc_valid         = (state != BOOT);
  assign redirect_pending = (state == PEND);
  assign pc_plus_inc      = pc + INC_V;
  assign accept           = pc_valid & imem_ready;
  // While a request is outstanding the presented address must not move.
  assign locked           = pc_valid & ~imem_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    pend_target_d = pend_target;
    pend_trap_d   = pend_trap;
    misaligned_d  = 1'b0;

    case (state)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (!locked) begin
          if (trap_valid) begin
            pc_d         = align(trap_target);
            misaligned_d = has_low_bits(trap_target);
          end else if (redirect_valid) begin
            pc_d         = align(redirect_target);
            misaligned_d = has_low_bits(redirect_target);
          end else if (!stall) begin
            pc_d = pc_plus_inc;
          end
        end else if (trap_valid) begin
          pend_target_d = align(trap_target);
          pend_trap_d   = 1'b1;
          misaligned_d  = has_low_bits(trap_target);
          state_d       = PEND;
        end else if (redirect_valid) begin
          pend_target_d = align(redirect_target);
          pend_trap_d   = 1'b0;
          misaligned_d  = has_low_bits(redirect_target);
          state_d       = PEND;
        end
      end

      PEND: begin
        if (locked) begin
          // A queued trap outranks any later redirect; only a trap may replace it.
          if (trap_valid) begin
            pend_target_d = align(trap_target);
            pend_trap_d   = 1'b1;
            misaligned_d  = has_low_bits(trap_target);
          end else if (redirect_valid && !pend_trap) begin
            pend_target_d = align(redirect_target);
            misaligned_d  = has_low_bits(redirect_target);
          end
        end else begin
          state_d     = RUN;
          pend_trap_d = 1'b0;
          if (trap_valid) begin
            pc_d         = align(trap_target);
            misaligned_d = has_low_bits(trap_target);
          end else if (pend_trap) begin
            pc_d = pend_target;
          end else if (redirect_valid) begin
            pc_d         = align(redirect_target);
            misaligned_d = has_low_bits(redirect_target);
          end else begin
            pc_d = pend_target;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pend_target <= '0;
      pend_trap   <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend_target <= pend_target_d;
      pend_trap   <= pend_trap_d;
      misaligned  <= misaligned_d;
      if (accept) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined core's fetch stage. It holds the fetch address across stalls and presents it to instruction memory through a valid/ready handshake. It applies branch redirects and trap vectors with fixed priority, and queues a redirect that arrives while a fetch request is outstanding. It also counts accepted fetches for performance monitoring.

## Interface
Parameters:
- XLEN, 32, address width
- INC, 4, byte increment per sequential fetch; power of two, at least 2
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; must be INC-aligned
- CNT_W, 32, width of the fetch counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit hold; no sequential advance while high
- redirect_valid  in  1  branch/jump resolved in EX, one-cycle pulse
- redirect_target  in  XLEN  redirect address
- trap_valid  in  1  exception/interrupt entry, one-cycle pulse
- trap_target  in  XLEN  trap vector address
- imem_ready  in  1  instruction memory accepts the current request
- pc  out  XLEN  current fetch address
- pc_valid  out  1  fetch request valid
- pc_plus_inc  out  XLEN  pc + INC, combinational, wraps modulo 2^XLEN
- redirect_pending  out  1  a queued target is waiting to be applied
- misaligned  out  1  one-cycle pulse when an applied or queued target had nonzero low log2(INC) bits
- fetch_count  out  CNT_W  number of accepted fetches

## Operation
- States: BOOT, RUN, PEND.
- Reset (async, while reset_n=0) drives these values:
  - pc=RESET_VECTOR, pc_valid=0, state=BOOT
  - pending target=0, pending-is-trap=0
  - redirect_pending=0, misaligned=0, fetch_count=0
- BOOT -> RUN on the first clk edge after reset_n rises. pc stays RESET_VECTOR; pc_valid=1 from then on. Redirect and trap inputs are ignored in BOOT.
- Definitions:
  - accept = pc_valid & imem_ready
  - locked = pc_valid & ~imem_ready, meaning pc must stay stable while a request is outstanding
- In RUN, when not locked, priority order is:
  - trap_valid: pc <= trap_target
  - redirect_valid: pc <= redirect_target
  - ~stall: pc <= pc_plus_inc
  - otherwise pc holds
- Stall never blocks trap or redirect; a flush overrides a stall.
- In RUN, when locked:
  - trap or redirect is captured into the pending register, pending-is-trap is recorded, and state -> PEND.
  - pc holds; with trap and redirect together, trap is captured.
- In PEND, while still locked:
  - A new trap overwrites the pending target.
  - A new redirect overwrites only a pending redirect, never a pending trap.
- In PEND, when unlocked, next pc is chosen in this order, and state -> RUN:
  - new trap_valid
  - pending trap
  - new redirect_valid
  - pending redirect
- stall does not delay application of a pending target.
- redirect_pending = (state==PEND).
- Alignment rules:
  - Every target has its low log2(INC) bits forced to 0 before use.
  - misaligned pulses high for the cycle after any target with nonzero low bits is captured or applied.
  - A dropped lower-priority same-cycle target does not flag.
- fetch_count increments by 1 on every accept and wraps at 2^CNT_W.

## Timing
- All registered outputs update on the rising edge of clk; reset is asynchronous.
- Latency:
  - Redirect or trap while unlocked: new pc visible the cycle after the pulse.
  - While locked: new pc visible the cycle after the accept that unlocks.
- Handshake:
  - pc_valid stays 1 continuously in RUN/PEND.
  - pc must not change while locked.
  - A request accepted with stall=1 counts once; the held pc is re-presented next cycle and counts again if accepted.
- Wrap-around: pc at 2^XLEN-INC advances to 0 with no flag.
- Reset asserted mid-PEND discards the pending target immediately.

## Test plan
- Reset/boot: release reset_n, imem_ready=1 -> pc=0, pc_valid=0 for one cycle, then pc sequence 0,4,8,12; fetch_count=3 after three accepted cycles.
- Stall hold: pc=0x20, stall=1 for 3 cycles -> pc stays 0x20 (not 0x1C); after release -> 0x24.
- Redirect/trap priority: unlocked at pc=0x40, redirect 0x200 and trap 0x100 in the same cycle -> pc=0x100 next cycle, misaligned=0.
- Queued redirect:
  - Setup: imem_ready=0 at pc=0x80, redirect 0x300.
  - Expected: redirect_pending=1 and pc=0x80 held while locked.
  - After imem_ready=1: pc=0x300 next cycle, redirect_pending=0.
- Pending trap protection:
  - Setup: locked; trap 0x100, then redirect 0x500 while still locked.
  - Expected: 0x100 applied on unlock.
- Misalignment and wrap:
  - redirect_target 0x203 -> pc=0x200 and a one-cycle misaligned pulse.
  - pc=0xFFFF_FFFC advancing -> pc=0.
